// File: rtl/wrb_issue_buffer.sv
// wrb_issue_buffer
//   Writeback issue buffer between six writeback producers and the two
//   physical-regfile write ports. Each producer owns a small FIFO with
//   valid/ready backpressure. A round-robin arbiter pops up to two FIFO heads
//   per cycle onto wr_first / wr_second, so no writeback is lost when more
//   than two units complete in the same cycle.
//
// Ports
//   clk                  : clock, rising edge
//   rst_n                : asynchronous active-low reset
//   src_valid_i   [5:0]  : per-source valid (0 alu1, 1 alu2, 2 falu1, 3 falu2, 4 lsu, 5 md)
//   src_ready_o   [5:0]  : per-source ready (registered count only)
//   src_address_i        : 6 x REG_SIZE_WIDTH destination registers, slice k = source k
//   src_data_i           : 6 x XLEN writeback data, slice k = source k
//   wr_first_*_o         : regfile write port 1 (valid/address/data)
//   wr_second_*_o        : regfile write port 2 (valid/address/data)
//   stall_cnt_o   [31:0] : saturating count of cycles with any producer stalled
//                          (present only when WRB_STALL_CNT_EN is defined)
//
// Optional feature macro: WRB_STALL_CNT_EN

module wrb_issue_buffer #(
  parameter int REG_SIZE_WIDTH = 6,
  parameter int XLEN           = 64,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [5:0]                  src_valid_i,
  output logic [5:0]                  src_ready_o,
  input  logic [6*REG_SIZE_WIDTH-1:0] src_address_i,
  input  logic [6*XLEN-1:0]           src_data_i,
  output logic                        wr_first_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]   wr_first_address_o,
  output logic [XLEN-1:0]             wr_first_data_o,
  output logic                        wr_second_valid_o,
  output logic [REG_SIZE_WIDTH-1:0]   wr_second_address_o,
  output logic [XLEN-1:0]             wr_second_data_o
`ifdef WRB_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int unsigned NSRC = 6;
  localparam int          PW   = $clog2(FIFO_DEPTH);
  localparam int          CW   = PW + 1;
  localparam int          RW   = REG_SIZE_WIDTH;

  logic [RW-1:0]   r_fifo_addr [NSRC][FIFO_DEPTH];
  logic [XLEN-1:0] r_fifo_data [NSRC][FIFO_DEPTH];
  logic [PW-1:0]   r_rd_ptr    [NSRC];
  logic [PW-1:0]   r_wr_ptr    [NSRC];
  logic [CW-1:0]   r_count     [NSRC];
  logic [2:0]      r_rr_ptr;

  logic [NSRC-1:0] w_nonempty;
  logic [NSRC-1:0] w_push;
  logic [NSRC-1:0] w_pop;
  logic [RW-1:0]   w_head_addr [NSRC];
  logic [XLEN-1:0] w_head_data [NSRC];

  logic            w_first_found;
  logic            w_second_found;
  logic            w_second_ok;
  logic [2:0]      w_first_idx;
  logic [2:0]      w_second_idx;
  int unsigned     w_idx;

  // Ready, FIFO heads and enqueue qualification. Address 0 transfers are
  // accepted but never stored, since P0 is hardwired to zero.
  always_comb begin
    for (int unsigned k = 0; k < NSRC; k++) begin
      src_ready_o[k]  = (r_count[k] != CW'(FIFO_DEPTH));
      w_nonempty[k]   = (r_count[k] != '0);
      w_head_addr[k]  = r_fifo_addr[k][r_rd_ptr[k]];
      w_head_data[k]  = r_fifo_data[k][r_rd_ptr[k]];
      w_push[k]       = src_valid_i[k] && src_ready_o[k] &&
                        (src_address_i[k*RW +: RW] != '0);
    end
  end

  // Cyclic search from rr_ptr: first non-empty source takes port 1, the next
  // one takes port 2 unless it targets the same register.
  always_comb begin
    w_first_found  = 1'b0;
    w_second_found = 1'b0;
    w_first_idx    = '0;
    w_second_idx   = '0;
    w_idx          = 0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      w_idx = (32'(r_rr_ptr) + i) % NSRC;
      if (w_nonempty[w_idx[2:0]]) begin
        if (!w_first_found) begin
          w_first_found = 1'b1;
          w_first_idx   = w_idx[2:0];
        end else if (!w_second_found) begin
          w_second_found = 1'b1;
          w_second_idx   = w_idx[2:0];
        end
      end
    end
    w_second_ok = w_second_found &&
                  (w_head_addr[w_second_idx] != w_head_addr[w_first_idx]);

    w_pop = '0;
    if (w_first_found) w_pop[w_first_idx]  = 1'b1;
    if (w_second_ok)   w_pop[w_second_idx] = 1'b1;

    wr_first_valid_o    = w_first_found;
    wr_first_address_o  = w_first_found ? w_head_addr[w_first_idx]  : '0;
    wr_first_data_o     = w_first_found ? w_head_data[w_first_idx]  : '0;
    wr_second_valid_o   = w_second_ok;
    wr_second_address_o = w_second_ok   ? w_head_addr[w_second_idx] : '0;
    wr_second_data_o    = w_second_ok   ? w_head_data[w_second_idx] : '0;
  end

  // Entry storage needs no reset: validity is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (w_push[k]) begin
        r_fifo_addr[k][r_wr_ptr[k]] <= src_address_i[k*RW +: RW];
        r_fifo_data[k][r_wr_ptr[k]] <= src_data_i[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        r_rd_ptr[k] <= '0;
        r_wr_ptr[k] <= '0;
        r_count[k]  <= '0;
      end
      r_rr_ptr <= '0;
    end else begin
      for (int unsigned k = 0; k < NSRC; k++) begin
        if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + PW'(1);
        if (w_pop[k])  r_rd_ptr[k] <= r_rd_ptr[k] + PW'(1);
        if (w_push[k] && !w_pop[k])      r_count[k] <= r_count[k] + CW'(1);
        else if (!w_push[k] && w_pop[k]) r_count[k] <= r_count[k] - CW'(1);
      end
      if (w_second_ok)
        r_rr_ptr <= (w_second_idx == 3'd5) ? 3'd0 : w_second_idx + 3'd1;
      else if (w_first_found)
        r_rr_ptr <= (w_first_idx == 3'd5) ? 3'd0 : w_first_idx + 3'd1;
    end
  end

`ifdef WRB_STALL_CNT_EN
  logic w_stall;
  assign w_stall = |(src_valid_i & ~src_ready_o);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_o <= '0;
    else if (w_stall && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_wrb_issue_buffer.sv
// Directed testbench for wrb_issue_buffer (default parameters, FIFO_DEPTH=2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.

module tb_wrb_issue_buffer;

  localparam int RW = 6;
  localparam int XW = 64;

  logic          clk;
  logic          rst_n;
  logic [5:0]    src_valid;
  logic [5:0]    src_ready;
  logic [6*RW-1:0] src_addr;
  logic [6*XW-1:0] src_data;
  logic          f_valid, s_valid;
  logic [RW-1:0] f_addr, s_addr;
  logic [XW-1:0] f_data, s_data;
`ifdef WRB_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit p0_seen = 0;

  wrb_issue_buffer #(.REG_SIZE_WIDTH(RW), .XLEN(XW), .FIFO_DEPTH(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .src_valid_i         (src_valid),
    .src_ready_o         (src_ready),
    .src_address_i       (src_addr),
    .src_data_i          (src_data),
    .wr_first_valid_o    (f_valid),
    .wr_first_address_o  (f_addr),
    .wr_first_data_o     (f_data),
    .wr_second_valid_o   (s_valid),
    .wr_second_address_o (s_addr),
    .wr_second_data_o    (s_data)
`ifdef WRB_STALL_CNT_EN
    ,
    .stall_cnt_o         (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((f_valid && f_addr == '0) || (s_valid && s_addr == '0)) p0_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
  endtask

  task automatic set_src(input int k, input logic [RW-1:0] a, input logic [XW-1:0] d);
    src_valid[k]        = 1'b1;
    src_addr[k*RW +: RW] = a;
    src_data[k*XW +: XW] = d;
  endtask

  task automatic do_reset();
    clear_src();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic chk_ports(input string tag, input logic fv, input logic [RW-1:0] fa,
                           input logic [XW-1:0] fd, input logic sv,
                           input logic [RW-1:0] sa, input logic [XW-1:0] sd);
    chk({tag, "_fv"}, 64'(f_valid), 64'(fv));
    if (fv) begin
      chk({tag, "_fa"}, 64'(f_addr), 64'(fa));
      chk({tag, "_fd"}, f_data, fd);
    end
    chk({tag, "_sv"}, 64'(s_valid), 64'(sv));
    if (sv) begin
      chk({tag, "_sa"}, 64'(s_addr), 64'(sa));
      chk({tag, "_sd"}, s_data, sd);
    end
  endtask

  logic [XW-1:0] lsu_q[$];
  int            outstanding;
  logic [XW-1:0] lsu_seq;
  bit            bp_seen;

  task automatic lsu_observe(input logic v, input logic [RW-1:0] a, input logic [XW-1:0] d);
    if (v && a == RW'(30)) begin
      if (lsu_q.size() == 0) begin
        chk("bp_unexpected_lsu", d, 64'hDEAD);
      end else begin
        chk("bp_order", d, lsu_q[0]);
        void'(lsu_q.pop_front());
        outstanding--;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    clear_src();

    // Single write
    do_reset();
    chk("rst_ready", 64'(src_ready), 64'h3F);
    chk_ports("rst_ports", 1'b0, '0, '0, 1'b0, '0, '0);
    chk("rst_fa", 64'(f_addr), 64'h0);
    chk("rst_fd", f_data, 64'h0);
    chk("rst_sa", 64'(s_addr), 64'h0);
    chk("rst_sd", s_data, 64'h0);
`ifdef WRB_STALL_CNT_EN
    chk("rst_stall", 64'(stall_cnt), 64'h0);
`endif
    set_src(0, 6'd5, 64'hA5);
    step();
    clear_src();
    chk_ports("single_c1", 1'b1, 6'd5, 64'hA5, 1'b0, '0, '0);
    step();
    chk_ports("single_c2", 1'b0, '0, '0, 1'b0, '0, '0);

    // Six-way burst, then prove rr_ptr is back at 0
    do_reset();
    for (int k = 0; k < 6; k++) set_src(k, RW'(k + 1), 64'(100 + k));
    step();
    clear_src();
    chk_ports("burst_c1", 1'b1, 6'd1, 64'd100, 1'b1, 6'd2, 64'd101);
    step();
    chk_ports("burst_c2", 1'b1, 6'd3, 64'd102, 1'b1, 6'd4, 64'd103);
    step();
    chk_ports("burst_c3", 1'b1, 6'd5, 64'd104, 1'b1, 6'd6, 64'd105);
    set_src(0, 6'd10, 64'h10);
    set_src(5, 6'd11, 64'h11);
    step();
    clear_src();
    chk_ports("rr_wrap", 1'b1, 6'd10, 64'h10, 1'b1, 6'd11, 64'h11);
    step();
    chk_ports("rr_idle", 1'b0, '0, '0, 1'b0, '0, '0);

    // Backpressure on lsu while alu1/alu2 compete for the ports
    do_reset();
    outstanding = 0;
    lsu_seq     = 64'h1000;
    bp_seen     = 0;
    for (int c = 0; c < 24; c++) begin
      clear_src();
      if (c < 14) begin
        set_src(0, 6'd20, 64'h20);
        set_src(1, 6'd21, 64'h21);
        set_src(4, 6'd30, lsu_seq);
      end
      chk("bp_ready", 64'(src_ready[4]), 64'(outstanding != 2));
      if (!src_ready[4]) bp_seen = 1;
      lsu_observe(f_valid, f_addr, f_data);
      lsu_observe(s_valid, s_addr, s_data);
      if (src_valid[4] && src_ready[4]) begin
        lsu_q.push_back(lsu_seq);
        outstanding++;
        lsu_seq = lsu_seq + 64'd1;
      end
      step();
    end
    clear_src();
    chk("bp_seen", 64'(bp_seen), 64'h1);
    chk("bp_drained", 64'(lsu_q.size()), 64'h0);
    chk("bp_idle_fv", 64'(f_valid), 64'h0);

    // P0 writes are accepted and never stored
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_src(5, 6'd0, 64'hFFFF);
      chk("p0_ready", 64'(src_ready[5]), 64'h1);
      step();
    end
    clear_src();
    chk("p0_ready_after", 64'(src_ready[5]), 64'h1);
    chk_ports("p0_ports", 1'b0, '0, '0, 1'b0, '0, '0);

    // Duplicate address: second grant suppressed
    do_reset();
    set_src(0, 6'd9, 64'd1);
    set_src(1, 6'd9, 64'd2);
    step();
    clear_src();
    chk_ports("dup_c1", 1'b1, 6'd9, 64'd1, 1'b0, '0, '0);
    step();
    chk_ports("dup_c2", 1'b1, 6'd9, 64'd2, 1'b0, '0, '0);
    step();
    chk_ports("dup_c3", 1'b0, '0, '0, 1'b0, '0, '0);

    // Asynchronous reset with three entries buffered
    do_reset();
    set_src(0, 6'd1, 64'h1);
    set_src(1, 6'd2, 64'h2);
    set_src(2, 6'd3, 64'h3);
    step();
    clear_src();
    chk_ports("ar_pre", 1'b1, 6'd1, 64'h1, 1'b1, 6'd2, 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ports("ar_now", 1'b0, '0, '0, 1'b0, '0, '0);
    chk("ar_fa", 64'(f_addr), 64'h0);
    chk("ar_ready", 64'(src_ready), 64'h3F);
`ifdef WRB_STALL_CNT_EN
    chk("ar_stall", 64'(stall_cnt), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_ports("ar_after1", 1'b0, '0, '0, 1'b0, '0, '0);
    step();
    chk_ports("ar_after2", 1'b0, '0, '0, 1'b0, '0, '0);
    chk("ar_ready_after", 64'(src_ready), 64'h3F);

    chk("no_p0_write", 64'(p0_seen), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wrb_issue_buffer.md
Name: wrb_issue_buffer

Overview:
- Sits between the six writeback producers (alu1, alu2, falu1, falu2, lsu, md) and the physical regfile's two write ports.
- Buffers each producer's results in its own small FIFO and applies backpressure to the producer when that FIFO is full.
- Each cycle, a round-robin arbiter issues up to two buffered results onto wr_first / wr_second.
- This replaces combinational merging of unbounded writebacks; no writeback is lost when more than two units complete in one cycle.

Parameters:
- REG_SIZE_WIDTH, 6: physical register address width.
- XLEN, 64: writeback data width.
- FIFO_DEPTH, 2: entries per source FIFO. Legal values are 2, 4 or 8 (power of 2).

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- src_valid_i  in  6: per-source result valid. Bit order: 0 alu1, 1 alu2, 2 falu1, 3 falu2, 4 lsu, 5 md.
- src_ready_o  out  6: per-source ready; a transfer occurs when valid and ready are both 1.
- src_address_i  in  6*REG_SIZE_WIDTH: per-source destination physical register; slice k belongs to source k.
- src_data_i  in  6*XLEN: per-source writeback data; slice k belongs to source k.
- wr_first_valid_o  out  1: regfile write port 1 valid.
- wr_first_address_o  out  REG_SIZE_WIDTH: regfile write port 1 address.
- wr_first_data_o  out  XLEN: regfile write port 1 data.
- wr_second_valid_o  out  1: regfile write port 2 valid.
- wr_second_address_o  out  REG_SIZE_WIDTH: regfile write port 2 address.
- wr_second_data_o  out  XLEN: regfile write port 2 data.

Behaviour:
- Reset (async assert, sync release):
  - All FIFOs empty; rr_ptr = 0.
  - wr_*_valid_o = 0; wr_*_address_o = 0; wr_*_data_o = 0.
  - src_ready_o = 6'b111111.
- Ready:
  - src_ready_o[k] = (count[k] != FIFO_DEPTH), computed from registered count only.
  - No combinational path from dequeue to ready. A full FIFO that is dequeued this cycle still shows ready=0 this cycle.
- Enqueue:
  - On a transfer with address != 0, the entry is written at the tail.
  - On a transfer with address == 0, the entry is accepted and discarded, because P0 is hardwired to zero. Count is unchanged.
- Issue is combinational from the FIFO heads. The regfile always accepts, so there is no write-side ready.
- Minimum latency: a result accepted at edge N appears on a wr port in cycle N+1. There is no bypass.
- Arbitration:
  - First grant: the lowest non-empty source index at or after rr_ptr, searching cyclically mod 6.
  - Second grant: the next non-empty source after the first, cyclically, excluding the first.
  - If the second candidate's address equals the first's, the second grant is suppressed and that entry waits. Duplicate addresses are illegal under renaming; this rule only keeps the regfile write deterministic.
- Each granted FIFO pops exactly one entry per cycle; a single source never takes both ports.
- rr_ptr update:
  - After issue, rr_ptr <= (index of last grant + 1) mod 6.
  - With no grants, rr_ptr holds.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, pointers both advance.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits and distinguishes full from empty.
- When a port is not granted: its valid is 0, and its address/data are driven to 0.
- Reset mid-operation: all buffered entries are dropped immediately (asynchronously), and outputs go to their reset values. Producers are reset on the same rst_n.
- Fairness: any non-empty FIFO is issued within 3 cycles.

Optional Feature:
- Macro: WRB_STALL_CNT_EN.
- When defined, adds output stall_cnt_o [31:0].
  - Increments by 1 on each cycle in which any src_valid_i[k] & ~src_ready_o[k] is true.
  - Saturates at 32'hFFFFFFFF.
  - Reset value is 0.
- When undefined, the port and counter are absent. All other behaviour is identical.

Test Plan:
- Single write: reset, then alu1 sends addr 5, data 64'hA5 in cycle 0 -> cycle 1 shows wr_first_valid=1, addr 5, data 64'hA5, and wr_second_valid=0. Cycle 2 shows both valids 0.
- Six-way burst: all six sources valid in one cycle with addrs 1..6 -> issue order over cycles 1..3 is {1,2}, {3,4}, {5,6}, and rr_ptr returns to 0.
- Backpressure: FIFO_DEPTH=2, lsu valid every cycle while alu1/alu2 saturate the ports -> src_ready_o[4] drops to 0 after 2 stored entries. No lsu entry is lost, and all lsu data appears in order.
- P0 write: md sends addr 0, data 64'hFFFF -> accepted (ready=1), and no wr port ever shows addr 0.
- Duplicate address: alu1 and alu2 both send addr 9, data 1 and 2 -> cycle 1 issues only alu1 (data 1) on first. Cycle 2 issues alu2 (data 2).
- Async reset: assert rst_n=0 mid-cycle with 3 entries buffered -> outputs go to 0 immediately, src_ready_o=6'h3F, and after release no stale entry issues. With WRB_STALL_CNT_EN defined, stall_cnt_o reads 0.
